// File: rtl/fake_psx_controller.sv
`default_nettype none
// ============================================================================
// Module   : fake_psx_controller
// Purpose  : Emulated digital PSX pad (responder side of the pad link).
// Revision : 1.0 - initial release
// ============================================================================
module fake_psx_controller #(
    parameter logic [7:0] DEVICE_ID = 8'h41,
    parameter int         ACK_DELAY = 160,
    parameter int         ACK_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        att,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic        busy,
    output logic        poll_done
);

    localparam int DLY_EFF = (ACK_DELAY < 1) ? 1 : ACK_DELAY;
    localparam int WID_EFF = (ACK_WIDTH < 1) ? 1 : ACK_WIDTH;
    localparam int CNT_MAX = (DLY_EFF > WID_EFF) ? DLY_EFF : WID_EFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter starts at 1 on entry, so these targets give exact cycle counts.
    localparam logic [CNT_W-1:0] DLY_TGT = CNT_W'(DLY_EFF - 1);
    localparam logic [CNT_W-1:0] WID_TGT = CNT_W'(WID_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_ACK_WAIT  = 3'd2,
        ST_ACK_PULSE = 3'd3,
        ST_IGNORE    = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       att_sync_q, att_sync_d;
    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       cmd_sync_q, cmd_sync_d;
    logic [1:0]       vld_q, vld_d;
    logic             clk_prev_q, clk_prev_d;
    logic             armed_q, armed_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_q, rx_d;
    logic [15:0]      btn_q, btn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             poll_done_q, poll_done_d;

    logic       att_s, clk_s, cmd_s, clk_fall, clk_rise;
    logic [7:0] tx_cur, tx_nxt, rx_new;

    function automatic logic [7:0] tx_sel(input logic [2:0] idx, input logic [15:0] btn);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hFF;
            3'd1:    b = DEVICE_ID;
            3'd2:    b = 8'h5A;
            3'd3:    b = btn[7:0];
            3'd4:    b = btn[15:8];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    always_comb begin
        att_s    = att_sync_q[1];
        clk_s    = clk_sync_q[1];
        cmd_s    = cmd_sync_q[1];
        clk_fall = clk_prev_q & ~clk_s;
        clk_rise = ~clk_prev_q & clk_s;
        tx_cur   = tx_sel(byte_idx_q, btn_q);
        tx_nxt   = tx_sel(byte_idx_q + 3'd1, btn_q);
        rx_new   = rx_q;
        rx_new[bit_cnt_q] = cmd_s;
    end

    always_comb begin
        att_sync_d  = {att_sync_q[0], att};
        clk_sync_d  = {clk_sync_q[0], psx_clk};
        cmd_sync_d  = {cmd_sync_q[0], cmd};
        vld_d       = {vld_q[0], 1'b1};
        clk_prev_d  = clk_s;
        state_d     = state_q;
        armed_d     = armed_q;
        byte_idx_d  = byte_idx_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        btn_d       = btn_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        poll_done_d = 1'b0;

        if (att_s) begin
            // Deselect wins over everything; arm only once the sync chain holds real samples.
            state_d    = ST_IDLE;
            armed_d    = vld_q[1];
            byte_idx_d = 3'd0;
            bit_cnt_d  = 3'd0;
            rx_d       = 8'h00;
            cnt_d      = '0;
            data_d     = 1'b1;
            ack_d      = 1'b1;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                    if (armed_q) begin
                        state_d    = ST_SHIFT;
                        armed_d    = 1'b0;
                        byte_idx_d = 3'd0;
                        bit_cnt_d  = 3'd0;
                        rx_d       = 8'h00;
                        btn_d      = buttons;
                        busy_d     = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (clk_fall) begin
                        data_d = tx_cur[bit_cnt_q];
                    end else if (clk_rise) begin
                        rx_d = rx_new;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            data_d    = 1'b1;
                            cnt_d     = CNT_ONE;
                            if ((byte_idx_q == 3'd0 && rx_new != 8'h01) ||
                                (byte_idx_q == 3'd1 && rx_new != 8'h42)) begin
                                state_d = ST_IGNORE;
                            end else if (byte_idx_q == 3'd4) begin
                                state_d     = ST_DONE;
                                poll_done_d = 1'b1;
                            end else begin
                                state_d = ST_ACK_WAIT;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_ACK_WAIT, ST_ACK_PULSE: begin
                    if (clk_fall) begin
                        // Host stopped waiting for ack: start the next byte on this edge.
                        state_d    = ST_SHIFT;
                        ack_d      = 1'b1;
                        byte_idx_d = byte_idx_q + 3'd1;
                        bit_cnt_d  = 3'd0;
                        cnt_d      = '0;
                        data_d     = tx_nxt[0];
                    end else if (state_q == ST_ACK_WAIT) begin
                        if (cnt_q >= DLY_TGT) begin
                            state_d = ST_ACK_PULSE;
                            ack_d   = 1'b0;
                            cnt_d   = CNT_ONE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        if (cnt_q >= WID_TGT) begin
                            state_d    = ST_SHIFT;
                            ack_d      = 1'b1;
                            byte_idx_d = byte_idx_q + 3'd1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_IGNORE, ST_DONE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    data_d  = 1'b1;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            att_sync_q  <= 2'b11;
            clk_sync_q  <= 2'b11;
            cmd_sync_q  <= 2'b11;
            vld_q       <= 2'b00;
            clk_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
            byte_idx_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            btn_q       <= 16'hFFFF;
            cnt_q       <= '0;
            data_q      <= 1'b1;
            ack_q       <= 1'b1;
            busy_q      <= 1'b0;
            poll_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            att_sync_q  <= att_sync_d;
            clk_sync_q  <= clk_sync_d;
            cmd_sync_q  <= cmd_sync_d;
            vld_q       <= vld_d;
            clk_prev_q  <= clk_prev_d;
            armed_q     <= armed_d;
            byte_idx_q  <= byte_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            btn_q       <= btn_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            poll_done_q <= poll_done_d;
        end
    end

    assign data      = data_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign poll_done = poll_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fake_psx_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fake_psx_controller
// Purpose  : Directed host-side polls against the emulated pad.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fake_psx_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        att = 1'b1;
    logic        psx_clk = 1'b1;
    logic        cmd = 1'b1;
    logic [15:0] buttons = 16'hFFFF;
    logic        data, ack, busy, poll_done;

    int n_cmp = 0;
    int n_mis = 0;
    int pd_cnt = 0;
    int ack_low_cnt = 0;
    int data_low_cnt = 0;

    fake_psx_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .att       (att),
        .psx_clk   (psx_clk),
        .cmd       (cmd),
        .buttons   (buttons),
        .data      (data),
        .ack       (ack),
        .busy      (busy),
        .poll_done (poll_done)
    );

    always #31.25 clk = ~clk;

    always @(negedge clk) begin
        if (poll_done) pd_cnt <= pd_cnt + 1;
        if (!ack)      ack_low_cnt <= ack_low_cnt + 1;
        if (!data)     data_low_cnt <= data_low_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One host byte, LSB first, 32 clk per half bit; returns right after the last rising edge.
    task automatic xfer(input logic [7:0] c, input int nbits, input bit early, output logic [7:0] r);
        logic [7:0] rr;
        rr = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            psx_clk = 1'b0;
            cmd     = c[i];
            if (early && i == 0) begin
                tick(2);
                chk("early_ack_still_low", ack, 1'b0);
                tick(1);
                chk("early_ack_released", ack, 1'b1);
                tick(29);
            end else begin
                tick(32);
            end
            rr[i]   = data;
            psx_clk = 1'b1;
            if (i < nbits - 1) tick(32);
        end
        r = rr;
    endtask

    task automatic watch_ack(input int n, output int lo, output int hi);
        lo = 0;
        hi = 0;
        for (int k = 1; k <= n; k++) begin
            tick(1);
            if (ack == 1'b0 && lo == 0) lo = k;
            if (ack == 1'b1 && lo != 0 && hi == 0) hi = k;
        end
    endtask

    task automatic start_poll(input logic [15:0] btn);
        buttons = btn;
        att     = 1'b0;
        tick(8);
        chk("busy_after_select", busy, 1'b1);
    endtask

    task automatic end_poll();
        att = 1'b1;
        tick(2);
        chk("busy_hold_2", busy, 1'b1);
        tick(1);
        chk("busy_fall_3", busy, 1'b0);
        chk("data_idle_after_att", data, 1'b1);
        tick(4);
    endtask

    // Pin rising edge + 2 sync cycles + 160 delay -> low at cycle 162, 32 wide -> high at 194.
    task automatic byte_ack(input string tag, input logic [7:0] c, input logic [7:0] exp);
        logic [7:0] r;
        int lo, hi;
        xfer(c, 8, 1'b0, r);
        chk(tag, r, exp);
        watch_ack(200, lo, hi);
        chk("ack_fall_cycle", lo, 162);
        chk("ack_rise_cycle", hi, 194);
    endtask

    task automatic last_byte(input logic [7:0] exp);
        logic [7:0] r;
        int lo, hi, pd0;
        pd0 = pd_cnt;
        xfer(8'h00, 8, 1'b0, r);
        chk("rx_byte4", r, exp);
        watch_ack(200, lo, hi);
        chk("no_ack_byte4", lo, 0);
        chk("poll_done_once", pd_cnt - pd0, 1);
        chk("data_idle_done", data, 1'b1);
    endtask

    task automatic full_poll(input logic [15:0] btn);
        byte_ack("rx_byte0", 8'h01, 8'hFF);
        byte_ack("rx_byte1", 8'h42, 8'h41);
        byte_ack("rx_byte2", 8'h00, 8'h5A);
        byte_ack("rx_byte3", 8'h00, btn[7:0]);
        last_byte(btn[15:8]);
    endtask

    initial begin
        logic [7:0] r;
        int lo, hi, pd0, al0, dl0;

        // Reset held with the host active
        att = 1'b0;
        for (int i = 0; i < 4; i++) begin
            psx_clk = ~psx_clk;
            tick(3);
            chk("rst_data", data, 1'b1);
            chk("rst_ack", ack, 1'b1);
            chk("rst_busy", busy, 1'b0);
        end
        psx_clk = 1'b1;
        rst_n   = 1'b1;
        tick(4);
        xfer(8'h01, 8, 1'b0, r);
        chk("post_rst_no_response", r, 8'hFF);
        watch_ack(200, lo, hi);
        chk("post_rst_no_ack", lo, 0);
        chk("post_rst_not_busy", busy, 1'b0);
        att = 1'b1;
        tick(4);

        // Full poll, one button pressed
        start_poll(16'hFFFE);
        full_poll(16'hFFFE);
        end_poll();

        // Bad first byte, then rearm with a single-cycle att pulse
        start_poll(16'hFFFF);
        xfer(8'h03, 8, 1'b0, r);
        chk("bad_first_rx", r, 8'hFF);
        watch_ack(200, lo, hi);
        chk("bad_first_no_ack", lo, 0);
        dl0 = data_low_cnt;
        xfer(8'h42, 8, 1'b0, r);
        chk("ignore_rx", r, 8'hFF);
        xfer(8'h00, 8, 1'b0, r);
        chk("ignore_data_high", data_low_cnt - dl0, 0);
        att = 1'b1;
        tick(1);
        start_poll(16'h12AB);
        full_poll(16'h12AB);
        end_poll();

        // Bad command byte
        start_poll(16'hFFFF);
        byte_ack("cmd_byte0", 8'h01, 8'hFF);
        xfer(8'h43, 8, 1'b0, r);
        chk("bad_cmd_rx", r, 8'h41);
        watch_ack(200, lo, hi);
        chk("bad_cmd_no_ack", lo, 0);
        xfer(8'h00, 8, 1'b0, r);
        chk("bad_cmd_ignore", r, 8'hFF);
        end_poll();

        // Att abort after three bits of byte 2
        start_poll(16'hFFFE);
        byte_ack("abort_byte0", 8'h01, 8'hFF);
        byte_ack("abort_byte1", 8'h42, 8'h41);
        pd0 = pd_cnt;
        al0 = ack_low_cnt;
        xfer(8'h00, 3, 1'b0, r);
        chk("abort_partial_rx", r, 8'h02);
        tick(16);
        chk("abort_data_before", data, 1'b0);
        att = 1'b1;
        tick(2);
        chk("abort_data_hold_2", data, 1'b0);
        tick(1);
        chk("abort_data_idle_3", data, 1'b1);
        chk("abort_busy_3", busy, 1'b0);
        tick(10);
        chk("abort_no_poll_done", pd_cnt - pd0, 0);
        chk("abort_no_ack", ack_low_cnt - al0, 0);
        start_poll(16'hFFFE);
        full_poll(16'hFFFE);
        end_poll();

        // Host starts byte 2 while ack is still low
        start_poll(16'h7F80);
        byte_ack("early_byte0", 8'h01, 8'hFF);
        xfer(8'h42, 8, 1'b0, r);
        chk("early_byte1", r, 8'h41);
        watch_ack(170, lo, hi);
        chk("early_ack_low", lo, 162);
        xfer(8'h00, 8, 1'b1, r);
        chk("early_byte2", r, 8'h5A);
        watch_ack(200, lo, hi);
        chk("early_b2_ack_fall", lo, 162);
        chk("early_b2_ack_rise", hi, 194);
        byte_ack("early_byte3", 8'h00, 8'h80);
        last_byte(8'h7F);
        end_poll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
